// File: rtl/accelerator_vector_series_scheduler_if.sv
// Bundle of the host-side vector handshake and the shared scalar-core handshake.
// The scheduler uses the slave view; the host/core environment uses the master view.
interface accelerator_vector_series_scheduler_if #(
  parameter int DATA_SIZE = 64
);
  logic                 start;
  logic [2:0]           operation;
  logic [DATA_SIZE-1:0] size_in;
  logic                 data_in_enable;
  logic [DATA_SIZE-1:0] data_in;
  logic                 ready;
  logic                 busy;
  logic                 error;
  logic                 data_out_enable;
  logic [DATA_SIZE-1:0] data_out;
  logic                 scalar_start;
  logic [2:0]           scalar_operation;
  logic [DATA_SIZE-1:0] scalar_data_in;
  logic                 scalar_ready;
  logic [DATA_SIZE-1:0] scalar_data_out;

  modport slave (
    input  start, operation, size_in, data_in_enable, data_in,
           scalar_ready, scalar_data_out,
    output ready, busy, error, data_out_enable, data_out,
           scalar_start, scalar_operation, scalar_data_in
  );

  modport master (
    output start, operation, size_in, data_in_enable, data_in,
           scalar_ready, scalar_data_out,
    input  ready, busy, error, data_out_enable, data_out,
           scalar_start, scalar_operation, scalar_data_in
  );
endinterface

// File: rtl/accelerator_vector_series_scheduler.sv
// Streams a vector one element at a time through a shared scalar series core,
// with a per-element timeout on the core and registered handshake outputs.
module accelerator_vector_series_scheduler #(
  parameter int DATA_SIZE = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  accelerator_vector_series_scheduler_if.slave io_vs
);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INPUT = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]           r_state;
  logic [DATA_SIZE-1:0] r_size;
  logic [DATA_SIZE-1:0] r_index;
  logic [TW-1:0]        r_timer;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_error;
  logic                 r_data_out_enable;
  logic [DATA_SIZE-1:0] r_data_out;
  logic                 r_scalar_start;
  logic [2:0]           r_scalar_operation;
  logic [DATA_SIZE-1:0] r_scalar_data_in;

  logic w_last_element;
  logic w_timer_expired;

  assign w_last_element  = (r_index == r_size - DATA_SIZE'(1));
  assign w_timer_expired = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state            <= S_IDLE;
      r_size             <= '0;
      r_index            <= '0;
      r_timer            <= '0;
      r_ready            <= 1'b0;
      r_busy             <= 1'b0;
      r_error            <= 1'b0;
      r_data_out_enable  <= 1'b0;
      r_data_out         <= '0;
      r_scalar_start     <= 1'b0;
      r_scalar_operation <= '0;
      r_scalar_data_in   <= '0;
    end else begin
      r_ready           <= 1'b0;
      r_error           <= 1'b0;
      r_data_out_enable <= 1'b0;
      r_scalar_start    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_vs.start) begin
            if (io_vs.operation > 3'd4) begin
              r_ready <= 1'b1;
              r_error <= 1'b1;
            end else if (io_vs.size_in == '0) begin
              r_ready <= 1'b1;
            end else begin
              r_scalar_operation <= io_vs.operation;
              r_size             <= io_vs.size_in;
              r_index            <= '0;
              r_busy             <= 1'b1;
              r_state            <= S_INPUT;
            end
          end
        end
        S_INPUT: begin
          if (io_vs.data_in_enable) begin
            r_scalar_start   <= 1'b1;
            r_scalar_data_in <= io_vs.data_in;
            r_timer          <= '0;
            r_state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The core cannot answer in its own launch cycle, so that cycle is neither sampled nor timed.
          if (!r_scalar_start) begin
            if (io_vs.scalar_ready) begin
              r_data_out        <= io_vs.scalar_data_out;
              r_data_out_enable <= 1'b1;
              r_index           <= r_index + DATA_SIZE'(1);
              if (w_last_element) begin
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_INPUT;
              end
            end else if (w_timer_expired) begin
              r_ready <= 1'b1;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_vs.ready            = r_ready;
  assign io_vs.busy             = r_busy;
  assign io_vs.error            = r_error;
  assign io_vs.data_out_enable  = r_data_out_enable;
  assign io_vs.data_out         = r_data_out;
  assign io_vs.scalar_start     = r_scalar_start;
  assign io_vs.scalar_operation = r_scalar_operation;
  assign io_vs.scalar_data_in   = r_scalar_data_in;
endmodule

// File: tb/tb_accelerator_vector_series_scheduler.sv
// Randomized bench: host driver, scalar-core model and event monitor, checked against
// per-operation expectations derived from the operation's inputs.
module tb_accelerator_vector_series_scheduler;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accelerator_vector_series_scheduler_if #(.DATA_SIZE(DW)) bus ();

  accelerator_vector_series_scheduler #(
    .DATA_SIZE(DW),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .io_vs(bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] x, input logic [2:0] op);
    return DW'(x * DW'(3) + DW'(op) + DW'(32'h5a));
  endfunction

  // Scalar core model: answers core_lat cycles after the launch cycle, or never when dead.
  int core_lat   = 1;
  bit core_dead  = 1'b0;
  bit core_stray = 1'b0;

  initial begin
    logic [DW-1:0] x;
    logic [2:0]    op;
    bus.scalar_ready    = 1'b0;
    bus.scalar_data_out = '0;
    forever begin
      @(negedge clk);
      bus.scalar_ready = 1'b0;
      if (bus.scalar_start) begin
        x  = bus.scalar_data_in;
        op = bus.scalar_operation;
        bus.scalar_ready    = core_stray;
        bus.scalar_data_out = ~x;
        if (!core_dead) begin
          for (int k = 0; k < core_lat; k++) begin
            @(negedge clk);
            bus.scalar_ready = 1'b0;
          end
          bus.scalar_ready    = 1'b1;
          bus.scalar_data_out = core_fn(x, op);
        end
      end
    end
  end

  // Monitor: only this process writes the running totals below.
  int            tot_ready  = 0;
  int            tot_err    = 0;
  int            tot_sstart = 0;
  int            tot_busy   = 0;
  int            ready_cyc  = -1;
  int            last_doe   = -1;
  int            sstart_cyc = -1;
  logic [DW-1:0] got_q[$];

  always @(negedge clk) begin
    if (bus.data_out_enable) begin
      got_q.push_back(bus.data_out);
      last_doe = cyc;
    end
    if (bus.ready) begin
      tot_ready++;
      ready_cyc = cyc;
    end
    if (bus.error) tot_err++;
    if (bus.scalar_start) begin
      tot_sstart++;
      sstart_cyc = cyc;
    end
    if (bus.busy) tot_busy++;
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ready"}, bus.ready, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_error"}, bus.error, 0);
    check_eq({tag, "_doe"}, bus.data_out_enable, 0);
    check_eq({tag, "_sstart"}, bus.scalar_start, 0);
    check_eq({tag, "_dout"}, bus.data_out, 0);
    check_eq({tag, "_sdin"}, bus.scalar_data_in, 0);
    check_eq({tag, "_sop"}, bus.scalar_operation, 0);
  endtask

  task automatic run_op(input logic [2:0] op, input int size, input int lat, input int dead_at);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] x;
    int  t, start_cyc, n_started, b_ready, b_err, b_sstart, b_busy, b_out, n_out;
    bit  legal, exp_err;
    legal     = (op <= 3'd4);
    exp_err   = !legal;
    n_started = 0;
    @(negedge clk);
    bus.data_in_enable = 1'b1;
    bus.data_in        = DW'($urandom);
    b_ready = tot_ready; b_err = tot_err; b_sstart = tot_sstart; b_busy = tot_busy;
    b_out   = got_q.size();
    @(negedge clk);
    bus.data_in_enable = 1'b0;
    bus.start          = 1'b1;
    bus.operation      = op;
    bus.size_in        = DW'(size);
    start_cyc          = cyc;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operation = 3'($urandom);
    bus.size_in   = DW'($urandom);
    if (legal) begin
      for (int e = 0; e < size; e++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        x          = DW'($urandom);
        core_lat   = (lat > 0) ? lat : int'($urandom_range(1, TO));
        core_dead  = (e == dead_at);
        core_stray = 1'($urandom_range(0, 1));
        bus.data_in_enable = 1'b1;
        bus.data_in        = x;
        bus.start          = 1'b1;
        n_started++;
        @(negedge clk);
        bus.data_in_enable = 1'b0;
        bus.start          = 1'b0;
        bus.data_in        = DW'($urandom);
        t = 0;
        while (!bus.data_out_enable && !bus.ready && t < TO + 10) begin
          @(negedge clk);
          t++;
        end
        check_eq("elem_in_time", t < TO + 10, 1);
        if (t >= TO + 10) break;
        if (e == dead_at) begin
          exp_err = 1'b1;
          break;
        end
        exp_q.push_back(core_fn(x, op));
      end
    end
    core_dead = 1'b0;
    t = 0;
    while (tot_ready == b_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    n_out = got_q.size() - b_out;
    check_eq("ready_pulses", tot_ready - b_ready, 1);
    check_eq("error_pulses", tot_err - b_err, exp_err);
    check_eq("out_count", n_out, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_out; i++)
      check_eq("out_data", got_q[b_out + i], exp_q[i]);
    check_eq("scalar_starts", tot_sstart - b_sstart, n_started);
    if (!legal || size == 0)
      check_eq("ready_latency", ready_cyc, start_cyc + 1);
    else if (exp_err)
      check_eq("timeout_latency", ready_cyc, sstart_cyc + TO + 1);
    else
      check_eq("ready_with_last", ready_cyc, last_doe);
    check_eq("busy_seen", (tot_busy - b_busy) > 0, legal && size > 0);
    check_eq("idle_after", bus.busy, 0);
    $display("op=%0d size=%0d lat=%0d dead_at=%0d results=%0d error=%0d", op, size, lat, dead_at,
             n_out, tot_err - b_err);
  endtask

  task automatic reset_mid_test();
    logic [DW-1:0] x;
    int t, b_ready, b_out;
    @(negedge clk);
    b_ready = tot_ready;
    b_out   = got_q.size();
    bus.start     = 1'b1;
    bus.operation = 3'd1;
    bus.size_in   = DW'(4);
    @(negedge clk);
    bus.start  = 1'b0;
    core_lat   = 2;
    core_dead  = 1'b0;
    core_stray = 1'b0;
    x          = DW'($urandom);
    bus.data_in_enable = 1'b1;
    bus.data_in        = x;
    @(negedge clk);
    bus.data_in_enable = 1'b0;
    t = 0;
    while (!bus.data_out_enable && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("rst_elem0_in_time", t < 20, 1);
    core_lat = 6;
    bus.data_in_enable = 1'b1;
    bus.data_in        = DW'($urandom);
    @(negedge clk);
    bus.data_in_enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("rst_mid");
    repeat (8) @(negedge clk);
    check_eq("rst_no_ready", tot_ready - b_ready, 0);
    check_eq("rst_out_count", got_q.size() - b_out, 1);
    if (got_q.size() > b_out) check_eq("rst_elem0_data", got_q[b_out], core_fn(x, 3'd1));
    check_eq("rst_idle", bus.busy, 0);
    $display("reset during element 2 of 4: results=%0d ready=%0d", got_q.size() - b_out,
             tot_ready - b_ready);
  endtask

  initial begin
    int sz, dead;
    rst                = 1'b1;
    bus.start          = 1'b0;
    bus.operation      = '0;
    bus.size_in        = '0;
    bus.data_in_enable = 1'b0;
    bus.data_in        = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    run_op(3'd3, 3, 5, -1);
    run_op(3'd6, 4, 5, -1);
    run_op(3'd5, 1, 1, -1);
    run_op(3'd7, 2, 1, -1);
    run_op(3'd0, 0, 1, -1);
    run_op(3'd2, 3, 3, 1);
    run_op(3'd4, 2, 2, -1);
    run_op(3'd1, 2, TO, -1);
    reset_mid_test();
    run_op(3'd2, 4, 0, -1);

    for (int n = 0; n < 25; n++) begin
      sz   = int'($urandom_range(0, 5));
      dead = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_op(3'($urandom_range(0, 7)), sz, ($urandom_range(0, 1) == 0) ? 0 : TO, dead);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
